// File: rtl/prf_free_list_if.sv
// prf_free_list_if
//   Bundles the dispatch, retire and status signals of the PRF free list.
//   The master modport is the pipeline side (dispatch + retire); the slave
//   modport is the free list itself.
//
//   Handshake: alloc_num != 0 is the request ("valid") and alloc_ok is the
//   grant ("ready"). A request is consumed only at a clock edge where both
//   are high. When alloc_ok is low nothing is consumed and the requester
//   must hold or re-issue. Frees and commits have no back-pressure: they are
//   taken every cycle they are presented.
//
//   Signals:
//     alloc_num        PRNs requested by dispatch this cycle (0..N)
//     alloc_prn        N packed PRNs at head..head+N-1 (slot i at [i*PW +: PW])
//     alloc_ok         request granted this cycle
//     free_valid       per-slot free strobe from retire
//     free_prn         N packed stale PRNs
//     commit_alloc_num retiring instructions that allocated a PRN this cycle
//     rollback         squash: head returns to the committed head
//     free_count       registered number of free PRNs
//     dbl_free_err     sticky double-free flag (0 unless the check is built)
interface prf_free_list_if #(
  parameter int N      = 2,
  parameter int PRF_SZ = 64
);
  localparam int PW  = $clog2(PRF_SZ);
  localparam int CW  = $clog2(N + 1);
  localparam int FCW = PW + 1;

  logic [CW-1:0]   alloc_num;
  logic [N*PW-1:0] alloc_prn;
  logic            alloc_ok;
  logic [N-1:0]    free_valid;
  logic [N*PW-1:0] free_prn;
  logic [CW-1:0]   commit_alloc_num;
  logic            rollback;
  logic [FCW-1:0]  free_count;
  logic            dbl_free_err;

  modport master (
    output alloc_num, free_valid, free_prn, commit_alloc_num, rollback,
    input  alloc_prn, alloc_ok, free_count, dbl_free_err
  );

  modport slave (
    input  alloc_num, free_valid, free_prn, commit_alloc_num, rollback,
    output alloc_prn, alloc_ok, free_count, dbl_free_err
  );
endinterface

// File: rtl/prf_free_list.sv
// prf_free_list
//   Circular-queue allocator of free physical register numbers for an
//   R10K-style physical register file. Dispatch takes up to N PRNs per cycle
//   from the head; retire returns up to N stale PRNs per cycle at the tail.
//   A committed head tracks the oldest allocation that has not yet
//   committed, so a squash restores the head in a single cycle.
//
//   Ports:
//     clock   system clock
//     reset   synchronous, active-high reset
//     fl      prf_free_list_if.slave (alloc/free/commit/rollback/status)
//
//   Optional build macro FREE_LIST_DBL_FREE_CHECK_EN: keeps a PRF_SZ-bit
//   bitmap of free PRNs and raises a sticky dbl_free_err when a PRN that is
//   already free is freed again, or the same PRN appears on two free slots
//   in one cycle. Without the macro dbl_free_err is tied low.
module prf_free_list #(
  parameter int N       = 2,
  parameter int PRF_SZ  = 64,
  parameter int ARCH_SZ = 32
) (
  input  logic            clock,
  input  logic            reset,
  prf_free_list_if.slave  fl
);
  localparam int PW  = $clog2(PRF_SZ);
  localparam int CW  = $clog2(N + 1);
  localparam int FCW = PW + 1;

  logic [PW-1:0]  entry [PRF_SZ];
  logic [PW-1:0]  head;
  logic [PW-1:0]  commit_head;
  logic [PW-1:0]  tail;
  logic [FCW-1:0] free_count_q;

  logic [PW-1:0]  aprn [N];
  logic [PW-1:0]  fprn [N];
  logic           alloc_ok_c;
  logic [CW-1:0]  grant_num;
  logic [N-1:0]   free_acc;
  logic [CW-1:0]  free_ofs [N];
  logic [CW-1:0]  free_cnt;
  logic [PW-1:0]  inflight;
  logic [FCW-1:0] free_count_nxt;
  logic [PW-1:0]  head_nxt;

  // Unpack the slot buses and present the head window combinationally.
  for (genvar g = 0; g < N; g++) begin : g_slot
    assign aprn[g] = entry[head + PW'(g)];
    assign fprn[g] = fl.free_prn[g*PW +: PW];
    assign fl.alloc_prn[g*PW +: PW] = aprn[g];
  end

  // All-or-nothing grant; a rollback cycle never allocates.
  assign alloc_ok_c = (FCW'(fl.alloc_num) <= free_count_q) && !fl.rollback;
  assign grant_num  = alloc_ok_c ? fl.alloc_num : '0;
  assign fl.alloc_ok   = alloc_ok_c;
  assign fl.free_count = free_count_q;

  // Compact accepted frees in slot order: each accepted slot gets the next
  // tail offset. PRN 0 is never a real free and is dropped here.
  always_comb begin
    free_cnt = '0;
    for (int i = 0; i < N; i++) begin
      free_acc[i] = fl.free_valid[i] && (fprn[i] != '0);
      free_ofs[i] = free_cnt;
      if (free_acc[i]) free_cnt = free_cnt + CW'(1);
    end
  end

  // PRNs handed out but not yet committed; modulo PRF_SZ by construction.
  assign inflight = head - commit_head;

  always_comb begin
    if (fl.rollback) begin
      // Everything past the post-commit head goes back on the list.
      head_nxt       = commit_head + PW'(fl.commit_alloc_num);
      free_count_nxt = free_count_q + FCW'(inflight)
                       - FCW'(fl.commit_alloc_num) + FCW'(free_cnt);
    end else begin
      head_nxt       = head + PW'(grant_num);
      free_count_nxt = free_count_q - FCW'(grant_num) + FCW'(free_cnt);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < PRF_SZ; k++) begin
        entry[k] <= (k < PRF_SZ - ARCH_SZ) ? PW'(ARCH_SZ + k) : '0;
      end
      head         <= '0;
      commit_head  <= '0;
      tail         <= PW'(PRF_SZ - ARCH_SZ);
      free_count_q <= FCW'(PRF_SZ - ARCH_SZ);
    end else begin
      for (int i = 0; i < N; i++) begin
        if (free_acc[i]) entry[tail + PW'(free_ofs[i])] <= fprn[i];
      end
      head         <= head_nxt;
      commit_head  <= commit_head + PW'(fl.commit_alloc_num);
      tail         <= tail + PW'(free_cnt);
      free_count_q <= free_count_nxt;
    end
  end

`ifdef FREE_LIST_DBL_FREE_CHECK_EN
  logic [PRF_SZ-1:0] bitmap;
  logic [PRF_SZ-1:0] bitmap_nxt;
  logic              dbl_hit;
  logic              dbl_err_q;

  // Order matters: allocations clear, squashed PRNs are set, then frees set.
  // The double-free test looks at the bitmap as it stood before this cycle.
  always_comb begin
    bitmap_nxt = bitmap;
    dbl_hit    = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (CW'(i) < grant_num) bitmap_nxt[aprn[i]] = 1'b0;
    end
    if (fl.rollback) begin
      // Squashed window: offsets [commit_alloc_num, inflight) from commit_head.
      for (int k = 0; k < PRF_SZ; k++) begin
        if ((PW'(k) >= PW'(fl.commit_alloc_num)) && (PW'(k) < inflight)) begin
          bitmap_nxt[entry[commit_head + PW'(k)]] = 1'b1;
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      if (free_acc[i]) begin
        if (bitmap[fprn[i]]) dbl_hit = 1'b1;
        for (int j = 0; j < i; j++) begin
          if (free_acc[j] && (fprn[j] == fprn[i])) dbl_hit = 1'b1;
        end
        bitmap_nxt[fprn[i]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < PRF_SZ; k++) bitmap[k] <= (k >= ARCH_SZ);
      dbl_err_q <= 1'b0;
    end else begin
      bitmap <= bitmap_nxt;
      if (dbl_hit) dbl_err_q <= 1'b1;
    end
  end

  assign fl.dbl_free_err = dbl_err_q;
`else
  assign fl.dbl_free_err = 1'b0;
`endif
endmodule

// File: tb/tb_prf_free_list.sv
// tb_prf_free_list
//   Directed bench for prf_free_list (N=2, PRF_SZ=64, ARCH_SZ=32).
//   The driver applies one cycle of inputs just after each rising edge and
//   pushes the values it expects the DUT to show during that cycle; the
//   monitor drains the queue on the falling edge and compares.
module tb_prf_free_list;
  localparam int N       = 2;
  localparam int PRF_SZ  = 64;
  localparam int ARCH_SZ = 32;
  localparam int PW      = 6;
  localparam int W       = 32;

  localparam int K_FC  = 0;
  localparam int K_P0  = 1;
  localparam int K_P1  = 2;
  localparam int K_OK  = 3;
  localparam int K_ERR = 4;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  prf_free_list_if #(.N(N), .PRF_SZ(PRF_SZ)) fl_if ();

  prf_free_list #(.N(N), .PRF_SZ(PRF_SZ), .ARCH_SZ(ARCH_SZ)) dut (
    .clock (clock),
    .reset (reset),
    .fl    (fl_if.slave)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int           kind_q[$];
  string        name_q[$];
  int           n_vec = 0;
  int           n_err = 0;

  task automatic expect_sig(input int kind, input string nm, input int v);
    exp_q.push_back(W'(v));
    kind_q.push_back(kind);
    name_q.push_back(nm);
  endtask

  function automatic logic [W-1:0] actual(input int kind);
    case (kind)
      K_FC:    return W'(fl_if.free_count);
      K_P0:    return W'(fl_if.alloc_prn[PW-1:0]);
      K_P1:    return W'(fl_if.alloc_prn[2*PW-1:PW]);
      K_OK:    return W'(fl_if.alloc_ok);
      default: return W'(fl_if.dbl_free_err);
    endcase
  endfunction

  // Monitor: compare every expectation posted for the current cycle.
  always @(negedge clock) begin
    while (exp_q.size() != 0) begin
      logic [W-1:0] ev;
      logic [W-1:0] av;
      int           k;
      string        nm;
      ev = exp_q.pop_front();
      k  = kind_q.pop_front();
      nm = name_q.pop_front();
      av = actual(k);
      n_vec++;
      if (av !== ev) begin
        n_err++;
        $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, av, ev, $time);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input int an, input int fv, input int p0, input int p1,
                       input int cn, input int rb);
    fl_if.alloc_num        = 2'(an);
    fl_if.free_valid       = 2'(fv);
    fl_if.free_prn         = {PW'(p1), PW'(p0)};
    fl_if.commit_alloc_num = 2'(cn);
    fl_if.rollback         = 1'(rb);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    tick();
    tick();
    reset = 1'b0;
  endtask

  int model_q[$];
  int last0, last1;
  int exp_err;

  initial begin
`ifdef FREE_LIST_DBL_FREE_CHECK_EN
    exp_err = 1;
`else
    exp_err = 0;
`endif
    do_reset();

    // Reset state, idle cycle.
    drive(0, 0, 0, 0, 0, 0);
    expect_sig(K_FC, "rst_free_count", 32);
    expect_sig(K_P0, "rst_prn0", 32);
    expect_sig(K_P1, "rst_prn1", 33);
    expect_sig(K_ERR, "rst_err", 0);
    tick();

    // Drain the list two at a time: PRNs 32..63 in order.
    for (int i = 0; i < 16; i++) begin
      drive(2, 0, 0, 0, 0, 0);
      expect_sig(K_FC, "drain_fc", 32 - 2 * i);
      expect_sig(K_P0, "drain_prn0", 32 + 2 * i);
      expect_sig(K_P1, "drain_prn1", 33 + 2 * i);
      expect_sig(K_OK, "drain_ok", 1);
      tick();
    end

    // Empty: any request is refused and nothing moves.
    drive(1, 0, 0, 0, 0, 0);
    expect_sig(K_FC, "empty_fc", 0);
    expect_sig(K_OK, "empty_ok", 0);
    tick();
    drive(1, 0, 0, 0, 0, 0);
    expect_sig(K_FC, "empty_hold_fc", 0);
    expect_sig(K_OK, "empty_hold_ok", 0);
    tick();

    // Free {slot1=7, slot0=5}: no same-cycle bypass.
    drive(1, 3, 5, 7, 0, 0);
    expect_sig(K_FC, "free_same_cycle_fc", 0);
    expect_sig(K_OK, "free_same_cycle_ok", 0);
    tick();
    // Slot0 carries PRN 0 (ignored), slot1 frees 9.
    drive(0, 3, 0, 9, 0, 0);
    expect_sig(K_FC, "free2_fc", 2);
    expect_sig(K_P0, "free2_prn0", 5);
    expect_sig(K_P1, "free2_prn1", 7);
    tick();
    drive(2, 0, 0, 0, 0, 0);
    expect_sig(K_FC, "free3_fc", 3);
    expect_sig(K_P0, "free3_prn0", 5);
    expect_sig(K_OK, "free3_ok", 1);
    tick();
    // One left (9): allocate it while freeing 40.
    drive(1, 1, 40, 0, 0, 0);
    expect_sig(K_FC, "last_fc", 1);
    expect_sig(K_P0, "last_prn0", 9);
    expect_sig(K_OK, "last_ok", 1);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    expect_sig(K_FC, "after_last_fc", 1);
    expect_sig(K_P0, "after_last_prn0", 40);
    expect_sig(K_ERR, "after_last_err", 0);
    tick();

    // Reset mid-operation, with rollback and alloc held high.
    reset = 1'b1;
    drive(2, 0, 0, 0, 0, 1);
    tick();
    reset = 1'b0;

    // Rollback: allocate 32..37, then commit 2 while squashing.
    for (int i = 0; i < 3; i++) begin
      drive(2, 0, 0, 0, 0, 0);
      expect_sig(K_FC, "rb_alloc_fc", 32 - 2 * i);
      expect_sig(K_P0, "rb_alloc_prn0", 32 + 2 * i);
      expect_sig(K_P1, "rb_alloc_prn1", 33 + 2 * i);
      expect_sig(K_OK, "rb_alloc_ok", 1);
      tick();
    end
    drive(2, 0, 0, 0, 2, 1);
    expect_sig(K_FC, "rb_cycle_fc", 26);
    expect_sig(K_OK, "rb_cycle_ok", 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    expect_sig(K_FC, "rb_after_fc", 30);
    expect_sig(K_P0, "rb_after_prn0", 34);
    expect_sig(K_P1, "rb_after_prn1", 35);
    expect_sig(K_ERR, "rb_after_err", 0);
    tick();

    // Wrap-around: steady alloc 2 / commit 2 / free last cycle's pair.
    do_reset();
    model_q.delete();
    for (int p = ARCH_SZ; p < PRF_SZ; p++) model_q.push_back(p);
    last0 = 0;
    last1 = 0;
    for (int c = 0; c < 100; c++) begin
      drive(2, (c > 0) ? 3 : 0, last0, last1, (c > 0) ? 2 : 0, 0);
      expect_sig(K_FC, "wrap_fc", (c == 0) ? 32 : 30);
      expect_sig(K_OK, "wrap_ok", 1);
      expect_sig(K_P0, "wrap_prn0", model_q[0]);
      expect_sig(K_P1, "wrap_prn1", model_q[1]);
      if (c > 0) begin
        model_q.push_back(last0);
        model_q.push_back(last1);
      end
      last0 = model_q.pop_front();
      last1 = model_q.pop_front();
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
    expect_sig(K_ERR, "wrap_err", 0);
    tick();

    // Double free of PRN 40 (already free after reset, and on both slots).
    do_reset();
    drive(0, 3, 40, 40, 0, 0);
    expect_sig(K_ERR, "dbl_before", 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    expect_sig(K_ERR, "dbl_set", exp_err);
    tick();
    expect_sig(K_ERR, "dbl_hold", exp_err);
    tick();
    do_reset();
    expect_sig(K_ERR, "dbl_cleared", 0);
    expect_sig(K_FC, "dbl_cleared_fc", 32);
    tick();

    // Every posted expectation must have been consumed.
    tick();
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
